sda_action_control: RTL and testbench
=====================================

# sda_action_control

Host-facing controller that sequences one teak kernel action. It decodes a 32-bit AXI4-Lite slave register map and drives the action's four-phase go/done handshake. It also keeps a run-cycle counter, a completed-run counter and a done interrupt. It sits between the SDAccel control-port AXI-Lite interconnect and the action top's `go_0*`/`done_0*` ports.

## Interface
- No parameters; register map and widths fixed.
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- s_axi_araddr  in  32  read address; bits [3:2] select register, others ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
- s_axi_awaddr  in  32  write address; bits [3:2] select register.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes; honoured on SCRATCH only, ignored elsewhere.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bresp  out  2  always 2'b00.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- go_0r  out  1  action start request.
- go_0a  in  1  action start acknowledge.
- done_0r  in  1  action completion request.
- done_0a  out  1  action completion acknowledge.
- irq  out  1  level interrupt, equals DONE & IRQ_EN.

## Operation
- Register map:
  - 0x0 CTRL: write bit0 START, bit1 DONE_CLR (write 1 to clear), bit8 IRQ_EN. Read bit0 BUSY, bit1 DONE, bit2 IDLE (=~BUSY), bit8 IRQ_EN.
  - 0x4 CYCLES: read-only.
  - 0x8 RUNS: read-only.
  - 0xC SCRATCH: read/write.
- Unmapped bits read 0. Writes to read-only registers are accepted with OKAY and have no effect.
- FSM states and transitions:
  - IDLE: START=1 moves to GO_REQ.
  - GO_REQ: go_0r=1. Leaves to GO_REL when go_0a=1.
  - GO_REL: go_0r=0. Leaves to WAIT_DONE when go_0a=0.
  - WAIT_DONE: leaves to DONE_ACK when done_seen=1.
  - DONE_ACK: done_0a=1. Leaves to IDLE when done_0r=0.
- done_seen is a sticky flag. It is set by done_0r=1 sampled in GO_REQ, GO_REL or WAIT_DONE, and cleared on entering IDLE. This tolerates actions that raise done_0r together with go_0a, or pulse it for a single cycle.
- BUSY = state != IDLE.
- START written while BUSY is ignored.
- On the DONE_ACK→IDLE transition: DONE sets, RUNS increments (32-bit, wraps).
- DONE_CLR and the DONE set event on the same edge: set wins.
- START and DONE_CLR in one write: DONE clears and the run starts.
- CYCLES:
  - Cleared to 0 on the edge that leaves IDLE.
  - Increments by 1 on every edge while BUSY.
  - Saturates at 0xFFFF_FFFF.
  - Holds its value in IDLE.
- AXI write path:
  - Accepted only when awvalid & wvalid & ~bvalid & ~awready.
  - awready and wready pulse high together for one cycle; the register update happens on that same edge.
  - bvalid rises the next cycle and holds until bready.
- AXI read path:
  - Accepted only when arvalid & ~rvalid & ~arready.
  - arready pulses for one cycle. rdata is registered from that cycle's address, and rvalid rises the next cycle.
  - rdata is held stable until rready, and is 0 whenever rvalid=0.
- Read and write channels are independent and may complete in the same cycle. A read of CTRL returns the pre-edge state.

## Timing
- Reset values:
  - go_0r, done_0a, irq: 0.
  - All s_axi ready/valid outputs: 0; rdata 0; rresp and bresp 0.
  - FSM in IDLE; CTRL, CYCLES, RUNS, SCRATCH all 0.
- Reset asserted mid-run returns to IDLE next edge and drops go_0r/done_0a immediately. No DONE is set and RUNS is not incremented.
- Write accepted at edge T with START=1: go_0r=1 from T+1 and bvalid=1 from T+1.
- go_0r falls one cycle after go_0a is sampled high.
- done_0a rises one cycle after done_seen is set.
- IDLE is re-entered one cycle after done_0r is sampled low in DONE_ACK; DONE and irq are visible that cycle.
- Minimum run against a one-cycle-pulse action (go_0a=done_0r high one cycle): GO_REQ, GO_REL, WAIT_DONE, DONE_ACK = 4 busy cycles, so CYCLES=4.
- Throughput: one AXI write per 2 cycles with bready held high; same for reads with rready held high.

## Test plan
- Reset, then read all four registers -> CTRL=0x0000_0004 (IDLE), others 0. go_0r=0, done_0a=0, irq=0.
- Write SCRATCH=0xDEAD_BEEF with wstrb=4'b0101, then read -> 0x00AD_00EF. bresp and rresp = 0.
- Write CTRL=0x101 against an action that pulses go_0a and done_0r together for one cycle -> exactly one go_0r phase, done_0a high for 1 cycle. Then CTRL reads 0x106, CYCLES=4, RUNS=1, irq=1.
- Against an action with a 100-cycle delay between go_0a falling and done_0r rising:
  - Write START while BUSY -> no second go_0r, and RUNS=1 after the run completes.
  - Write DONE_CLR -> irq falls the cycle after the write is accepted.
- Assert reset for 1 cycle while in WAIT_DONE -> go_0r=0 and done_0a=0 afterwards, CTRL=0x004, RUNS=0. A subsequent START runs normally.
- Hold bready=0 for 10 cycles after a write -> bvalid stays 1, awready stays 0 for a second pending write, and that second write completes after bready rises.

Source files
------------

// File: rtl/sda_action_control.sv
// Host-facing AXI4-Lite register block that sequences one teak action through
// its four-phase go/done handshake, with run-cycle/run counters and a done irq.
module sda_action_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic        go_0r,
    input  logic        go_0a,
    input  logic        done_0r,
    output logic        done_0a,
    output logic        irq
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_GO_REQ, ST_GO_REL, ST_WAIT_DONE, ST_DONE_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        done_seen_q, done_seen_d;
    logic        done_q, done_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] runs_q, runs_d;
    logic [31:0] scratch_q, scratch_d;
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_en, rd_en, ctrl_wr, start_req, clr_req, busy, done_evt;
    logic [31:0] ctrl_rd;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                                s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_wdata[31:9]};

    assign wr_en     = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
    assign rd_en     = s_axi_arvalid & ~rvalid_q & ~arready_q;
    assign ctrl_wr   = wr_en & (s_axi_awaddr[3:2] == 2'd0);
    assign start_req = ctrl_wr & s_axi_wdata[0];
    assign clr_req   = ctrl_wr & s_axi_wdata[1];
    assign busy      = (state_q != ST_IDLE);
    assign done_evt  = (state_q == ST_DONE_ACK) & ~done_0r;
    assign ctrl_rd   = {23'd0, irq_en_q, 5'd0, ~busy, done_q, busy};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_req)   state_d = ST_GO_REQ;
            ST_GO_REQ:    if (go_0a)       state_d = ST_GO_REL;
            ST_GO_REL:    if (!go_0a)      state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_seen_q) state_d = ST_DONE_ACK;
            ST_DONE_ACK:  if (!done_0r)    state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_seen_d = done_seen_q;
        if (state_d == ST_IDLE)
            done_seen_d = 1'b0;
        else if (done_0r && (state_q == ST_GO_REQ || state_q == ST_GO_REL ||
                             state_q == ST_WAIT_DONE))
            done_seen_d = 1'b1;

        // Completion on the same edge as a DONE_CLR write keeps DONE set.
        done_d = done_q;
        if (done_evt)
            done_d = 1'b1;
        else if (clr_req)
            done_d = 1'b0;

        irq_en_d = ctrl_wr ? s_axi_wdata[8] : irq_en_q;
        runs_d   = done_evt ? runs_q + 32'd1 : runs_q;

        cycles_d = cycles_q;
        if (state_q == ST_IDLE && state_d != ST_IDLE)
            cycles_d = 32'd0;
        else if (busy && cycles_q != 32'hFFFF_FFFF)
            cycles_d = cycles_q + 32'd1;

        scratch_d = scratch_q;
        if (wr_en && s_axi_awaddr[3:2] == 2'd3) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b])
                    scratch_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
        end

        rdata_d = rdata_q;
        if (rd_en) begin
            case (s_axi_araddr[3:2])
                2'd0:    rdata_d = ctrl_rd;
                2'd1:    rdata_d = cycles_q;
                2'd2:    rdata_d = runs_q;
                default: rdata_d = scratch_q;
            endcase
        end else if (rvalid_q && s_axi_rready) begin
            rdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done_seen_q <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            cycles_q    <= 32'd0;
            runs_q      <= 32'd0;
            scratch_q   <= 32'd0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            cycles_q    <= cycles_d;
            runs_q      <= runs_d;
            scratch_q   <= scratch_d;
            awready_q   <= wr_en;
            arready_q   <= rd_en;
            rdata_q     <= rdata_d;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (s_axi_bready)
                bvalid_q <= 1'b0;
            if (rd_en)
                rvalid_q <= 1'b1;
            else if (s_axi_rready)
                rvalid_q <= 1'b0;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign go_0r         = (state_q == ST_GO_REQ);
    assign done_0a       = (state_q == ST_DONE_ACK);
    assign irq           = done_q & irq_en_q;
endmodule

// File: tb/tb_sda_action_control.sv
// Directed bench for sda_action_control: AXI-Lite register access plus
// go/done handshake runs against a pulse action and a slow action model.
module tb_sda_action_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic        go_0r;
    logic        go_0a = 1'b0;
    logic        done_0r = 1'b0;
    logic        done_0a;
    logic        irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sda_action_control dut (
        .clk(clk), .reset(reset),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a), .irq(irq)
    );

    // Action model: mode 0 pulses go_0a and done_0r together for one cycle;
    // mode 1 follows go_0r, then raises done_0r 100 cycles after go_0a falls.
    int amode = 0;
    int a_st = 0;
    int a_cnt = 0;
    bit pulsed = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            a_st = 0; a_cnt = 0; pulsed = 1'b0; go_0a = 1'b0; done_0r = 1'b0;
        end else if (amode == 0) begin
            if (go_0r && !pulsed) begin
                go_0a = 1'b1; done_0r = 1'b1; pulsed = 1'b1;
            end else begin
                go_0a = 1'b0; done_0r = 1'b0;
                if (!go_0r) pulsed = 1'b0;
            end
        end else begin
            case (a_st)
                0: if (go_0r) begin go_0a = 1'b1; a_st = 1; end
                1: if (!go_0r) begin go_0a = 1'b0; a_cnt = 0; a_st = 2; end
                2: begin
                    a_cnt++;
                    if (a_cnt == 100) begin done_0r = 1'b1; a_st = 3; end
                end
                default: if (done_0a) begin done_0r = 1'b0; a_st = 0; end
            endcase
        end
    end

    int   go_rises = 0;
    int   done_ack_cyc = 0;
    logic go_prev = 1'b0;
    always @(negedge clk) begin
        if (go_0r && !go_prev) go_rises++;
        go_prev = go_0r;
        if (done_0a) done_ack_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit got;
        got = 1'b0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (s_axi_awready) begin got = 1'b1; break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("wr_accept", got, 1);
        if (got) begin
            check("wready", s_axi_wready, 1);
            check("bvalid", s_axi_bvalid, 1);
            check("bresp", s_axi_bresp, 0);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        bit got;
        got = 1'b0;
        data = 'x;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (s_axi_arready) begin got = 1'b1; break; end
        end
        s_axi_arvalid = 1'b0;
        check("rd_accept", got, 1);
        if (got) begin
            check("rvalid", s_axi_rvalid, 1);
            check("rresp", s_axi_rresp, 0);
            data = s_axi_rdata;
        end
    endtask

    task automatic wait_irq(input int bound);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (irq) begin got = 1'b1; break; end
        end
        check("irq_wait", got, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int g0, d0;
        bit ok, got;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_go_0r", go_0r, 0);
        check("rst_done_0a", done_0a, 0);
        check("rst_irq", irq, 0);
        check("rst_axi_rdy", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        check("rst_axi_vld", {s_axi_bvalid, s_axi_rvalid}, 0);
        check("rst_rdata", s_axi_rdata, 0);
        reset = 1'b0;
        axi_read(32'h0, rd);  check("rst_ctrl", rd, 32'h4);
        axi_read(32'h4, rd);  check("rst_cycles", rd, 0);
        axi_read(32'h8, rd);  check("rst_runs", rd, 0);
        axi_read(32'hC, rd);  check("rst_scratch", rd, 0);
        @(posedge clk); #1;
        check("rdata_idle_zero", s_axi_rdata, 0);

        // SCRATCH byte strobes and read-only write
        axi_write(32'hC, 32'hDEAD_BEEF, 4'b0101);
        axi_read(32'hC, rd);  check("scratch_strb", rd, 32'h00AD_00EF);
        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        axi_read(32'h8, rd);  check("runs_ro", rd, 0);

        // One-cycle pulse action: minimum run
        amode = 0;
        g0 = go_rises; d0 = done_ack_cyc;
        axi_write(32'h0, 32'h101, 4'hF);
        check("pulse_go_0r", go_0r, 1);
        wait_irq(20);
        repeat (3) @(posedge clk);
        #1;
        check("pulse_go_phases", go_rises - g0, 1);
        check("pulse_done_0a_cyc", done_ack_cyc - d0, 1);
        axi_read(32'h0, rd);  check("pulse_ctrl", rd, 32'h106);
        axi_read(32'h4, rd);  check("pulse_cycles", rd, 4);
        axi_read(32'h8, rd);  check("pulse_runs", rd, 1);
        check("pulse_irq", irq, 1);

        // Slow action: START while busy ignored, then DONE_CLR drops irq
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        amode = 1;
        g0 = go_rises; d0 = done_ack_cyc;
        axi_write(32'h0, 32'h101, 4'hF);
        check("slow_go_0r", go_0r, 1);
        repeat (5) @(posedge clk);
        #1;
        axi_read(32'h0, rd);  check("slow_ctrl_busy", rd, 32'h101);
        axi_write(32'h0, 32'h101, 4'hF);
        wait_irq(300);
        repeat (3) @(posedge clk);
        #1;
        check("slow_go_phases", go_rises - g0, 1);
        check("slow_done_0a_cyc", done_ack_cyc - d0, 1);
        axi_read(32'h8, rd);  check("slow_runs", rd, 1);
        axi_read(32'h4, rd);  check("slow_cycles", rd, 104);
        axi_read(32'h0, rd);  check("slow_ctrl_done", rd, 32'h106);
        check("irq_before_clr", irq, 1);
        axi_write(32'h0, 32'h102, 4'hF);
        check("irq_after_clr", irq, 0);
        axi_read(32'h0, rd);  check("ctrl_after_clr", rd, 32'h104);

        // Reset during WAIT_DONE, then a clean run
        axi_write(32'h0, 32'h101, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_go_0r", go_0r, 0);
        check("midrst_done_0a", done_0a, 0);
        axi_read(32'h0, rd);  check("midrst_ctrl", rd, 32'h4);
        axi_read(32'h8, rd);  check("midrst_runs", rd, 0);
        axi_write(32'h0, 32'h101, 4'hF);
        wait_irq(300);
        axi_read(32'h8, rd);  check("postrst_runs", rd, 1);

        // Write response backpressure
        s_axi_bready = 1'b0;
        axi_write(32'hC, 32'h1111_1111, 4'hF);
        s_axi_awaddr = 32'hC; s_axi_wdata = 32'h2222_2222; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!s_axi_bvalid || s_axi_awready) ok = 1'b0;
        end
        check("bp_hold", ok, 1);
        axi_read(32'hC, rd);  check("bp_first_data", rd, 32'h1111_1111);
        s_axi_bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (s_axi_awready) begin got = 1'b1; break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("bp_second_accept", got, 1);
        axi_read(32'hC, rd);  check("bp_second_data", rd, 32'h2222_2222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
